// File: rtl/branch_ctrl.sv
// branch_ctrl - direct-mapped BTB with 2-bit counters, EX-stage mispredict redirect and perf counters.
module branch_ctrl #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             res;
  logic             mispredict;

  // Lookup reads the registered array only, so a same-index update is not bypassed.
  always_comb begin
    if_idx      = if_pc[IDX_W+1:2];
    if_tag      = if_pc[31:IDX_W+2];
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && ctr_q[if_idx][1];
    pred_target = if_hit ? target_q[if_idx] : (if_pc + 32'd4);
  end

  // Resolution is also gated by reset so nothing redirects while the block is held in reset.
  always_comb begin
    ex_idx      = ex_pc[IDX_W+1:2];
    ex_tag      = ex_pc[31:IDX_W+2];
    ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    res         = rst_n && ex_valid && ex_is_branch && !stall;
    mispredict  = res && ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));
    redirect    = mispredict;
    flush       = mispredict;
    redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'd0;
      end
    end else if (res) begin
      if (ex_hit) begin
        if (ex_taken) begin
          if (ctr_q[ex_idx] != 2'd3) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
        end else begin
          if (ctr_q[ex_idx] != 2'd0) ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= 2'd2;
      end
      if (branch_count != {CNT_W{1'b1}}) branch_count <= branch_count + 1'b1;
      if (mispredict && (mispredict_count != {CNT_W{1'b1}}))
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

  // Tags and targets carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (res && ex_taken) begin
      target_q[ex_idx] <= ex_target;
      if (!ex_hit) tag_q[ex_idx] <= ex_tag;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl - directed table-driven bench for branch_ctrl plus stall, bypass, saturation and reset sequences.
module tb_branch_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   if_pc = 32'h100;
  logic          stall = 1'b0;
  logic          ex_valid = 1'b0;
  logic          ex_is_branch = 1'b0;
  logic [31:0]   ex_pc = '0;
  logic          ex_taken = 1'b0;
  logic [31:0]   ex_target = '0;
  logic          ex_pred_taken = 1'b0;
  logic [31:0]   ex_pred_target = '0;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          flush;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  branch_ctrl #(.ENTRIES(16), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .stall(stall),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        br;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] look;
    logic        etk;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[16];
  int   errors = 0;
  int   checks = 0;
  int   bc = 0;
  int   mc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic b, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid = v; ex_is_branch = b; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, " branch_count"}, 32'(branch_count), 32'(bc));
    chk({tag, " mispredict_count"}, 32'(mispredict_count), 32'(mc));
  endtask

  task automatic bump(input logic mis);
    if (bc < 15) bc++;
    if (mis && mc < 15) mc++;
  endtask

  initial begin
    vecs[0]  = '{1, 1, 32'h100, 1, 32'h80,  0, 32'h104, 1, 32'h80,  32'h100, 1, 32'h80};
    vecs[1]  = '{1, 1, 32'h100, 1, 32'h80,  1, 32'h80,  0, 32'h80,  32'h100, 1, 32'h80};
    vecs[2]  = '{1, 1, 32'h100, 1, 32'h80,  1, 32'h80,  0, 32'h80,  32'h100, 1, 32'h80};
    vecs[3]  = '{1, 1, 32'h100, 1, 32'h80,  1, 32'h80,  0, 32'h80,  32'h100, 1, 32'h80};
    vecs[4]  = '{1, 1, 32'h100, 0, 32'h80,  1, 32'h80,  1, 32'h104, 32'h100, 1, 32'h80};
    vecs[5]  = '{1, 1, 32'h100, 0, 32'h80,  1, 32'h80,  1, 32'h104, 32'h100, 0, 32'h80};
    vecs[6]  = '{1, 1, 32'h100, 0, 32'h80,  0, 32'h80,  0, 32'h104, 32'h100, 0, 32'h80};
    vecs[7]  = '{1, 1, 32'h100, 0, 32'h80,  0, 32'h80,  0, 32'h104, 32'h100, 0, 32'h80};
    vecs[8]  = '{1, 1, 32'h100, 1, 32'h80,  0, 32'h104, 1, 32'h80,  32'h100, 0, 32'h80};
    vecs[9]  = '{1, 1, 32'h100, 1, 32'h80,  1, 32'h90,  1, 32'h80,  32'h100, 1, 32'h80};
    vecs[10] = '{1, 1, 32'h100, 1, 32'h200, 1, 32'h80,  1, 32'h200, 32'h100, 1, 32'h200};
    vecs[11] = '{1, 0, 32'h100, 1, 32'h300, 0, 32'h104, 0, 32'h300, 32'h100, 1, 32'h200};
    vecs[12] = '{0, 1, 32'h100, 1, 32'h300, 0, 32'h104, 0, 32'h300, 32'h100, 1, 32'h200};
    vecs[13] = '{1, 1, 32'h140, 1, 32'h300, 0, 32'h144, 1, 32'h300, 32'h100, 0, 32'h104};
    vecs[14] = '{1, 1, 32'h140, 1, 32'h300, 1, 32'h300, 0, 32'h300, 32'h140, 1, 32'h300};
    vecs[15] = '{1, 1, 32'hFFFFFFFC, 0, 32'h8, 1, 32'h8, 1, 32'h0, 32'hFFFFFFFC, 0, 32'h0};

    // Reset state, checked both while held and after release
    #2;
    chk("rst pred_taken", 32'(pred_taken), 0);
    chk("rst pred_target", pred_target, 32'h104);
    chk_counts("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst redirect", 32'(redirect), 0);
    chk("post-rst flush", 32'(flush), 0);
    chk("post-rst pred_taken", 32'(pred_taken), 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_ex(vecs[i].vld, vecs[i].br, vecs[i].pc, vecs[i].tk, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
      #2;
      chk($sformatf("v%0d redirect", i), 32'(redirect), 32'(vecs[i].redir));
      chk($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].redir));
      chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
      if (vecs[i].vld && vecs[i].br) bump(vecs[i].redir);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      if_pc = vecs[i].look;
      #1;
      chk($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].etk));
      chk($sformatf("v%0d pred_target", i), pred_target, vecs[i].etgt);
      chk_counts($sformatf("v%0d", i));
    end

    // Stall holds a mispredicting branch for 5 cycles with no effect
    @(negedge clk);
    if_pc = 32'h188;
    stall = 1'b1;
    drive_ex(1, 1, 32'h188, 1, 32'h500, 0, 32'h18C);
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("stall%0d redirect", i), 32'(redirect), 0);
      chk_counts($sformatf("stall%0d", i));
      @(negedge clk);
    end
    chk("stall no alloc", 32'(pred_taken), 0);
    stall = 1'b0;
    #2;
    chk("unstall redirect", 32'(redirect), 1);
    chk("unstall redirect_pc", redirect_pc, 32'h500);
    bump(1'b1);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    #1;
    chk("unstall pred_target", pred_target, 32'h500);
    chk_counts("unstall");

    // Same-cycle lookup and allocation to one index: lookup sees old contents
    @(negedge clk);
    if_pc = 32'h184;
    drive_ex(1, 1, 32'h184, 1, 32'h400, 0, 32'h188);
    #2;
    chk("nobypass pred_taken", 32'(pred_taken), 0);
    chk("nobypass pred_target", pred_target, 32'h188);
    bump(1'b1);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    #1;
    chk("alloc pred_taken", 32'(pred_taken), 1);
    chk("alloc pred_target", pred_target, 32'h400);
    chk_counts("alloc");

    // Drive the mispredict counter into saturation
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive_ex(1, 1, 32'h18C, 0, 32'h0, 1, 32'h600);
      #2;
      chk($sformatf("sat%0d redirect", i), 32'(redirect), 1);
      bump(1'b1);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      #1;
      chk_counts($sformatf("sat%0d", i));
    end
    chk("saturated mispredict_count", 32'(mispredict_count), 32'hF);

    // Asynchronous reset mid-cycle, with a mispredicting taken branch held in EX
    @(posedge clk);
    #2;
    drive_ex(1, 1, 32'h1C4, 1, 32'h600, 0, 32'h1C8);
    rst_n = 1'b0;
    bc = 0;
    mc = 0;
    #1;
    chk_counts("async rst");
    chk("async rst pred_taken", 32'(pred_taken), 0);
    chk("async rst pred_target", pred_target, 32'h188);
    chk("async rst redirect", 32'(redirect), 0);
    chk("async rst flush", 32'(flush), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    rst_n = 1'b1;
    if_pc = 32'h1C4;
    #1;
    chk("rst discard pred_taken", 32'(pred_taken), 0);
    chk("rst discard pred_target", pred_target, 32'h1C8);
    chk_counts("rst release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter ENTRIES, default 16, number of BTB entries (power of two, 4..64).
REQ-002 Parameter CNT_W, default 32, width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 if_pc  in  32  fetch-stage PC to be predicted.
REQ-006 stall  in  1  pipeline hold; EX contents repeat while high.
REQ-007 ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
REQ-008 ex_is_branch  in  1  EX instruction is a conditional branch.
REQ-009 ex_pc  in  32  PC of the EX instruction.
REQ-010 ex_taken  in  1  resolved direction from the branch unit.
REQ-011 ex_target  in  32  resolved target (pc+imm) from the branch unit.
REQ-012 ex_pred_taken  in  1  prediction made for this instruction at IF, piped along.
REQ-013 ex_pred_target  in  32  predicted target made at IF, piped along.
REQ-014 pred_taken  out  1  IF prediction: fetch pred_target next.
REQ-015 pred_target  out  32  predicted target for if_pc.
REQ-016 redirect  out  1  mispredict; fetch must restart at redirect_pc.
REQ-017 redirect_pc  out  32  corrected fetch address.
REQ-018 flush  out  1  kill IF/ID and ID/EX contents this cycle.
REQ-019 branch_count  out  CNT_W  resolved branches since reset.
REQ-020 mispredict_count  out  CNT_W  mispredicts since reset.

Function
REQ-021 BTB: ENTRIES direct-mapped entries {valid, tag, target[31:0], ctr[1:0]}; index = pc[2+log2(ENTRIES)-1:2], tag = remaining pc[31:2+log2(ENTRIES)].
REQ-022 Lookup combinational on if_pc: hit = valid && tag match; pred_taken = hit && ctr[1]; pred_target = hit ? target : if_pc+4.
REQ-023 Resolve event (res) = ex_valid && ex_is_branch && !stall; nothing updates while stall=1.
REQ-024 Mispredict = res && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
REQ-025 redirect = flush = mispredict, combinational, same cycle as resolution.
REQ-026 redirect_pc = ex_taken ? ex_target : ex_pc+4 (mod 2^32 wrap).
REQ-027 Update on res, next edge: entry hit -> ctr saturating +1 if taken, -1 if not taken (floor 0, ceiling 3); if taken also write target.
REQ-028 Update on res with miss: taken -> allocate (valid=1, tag, target=ex_target, ctr=2), overwriting any occupant; not taken -> no change.
REQ-029 Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass).
REQ-030 branch_count +1 per res; mispredict_count +1 per mispredict; both saturate at all-ones, never wrap.
REQ-031 Non-branch or ex_valid=0 in EX: no update, redirect=0.

Reset
REQ-032 rst_n low: all valid bits 0, all ctr 0, both counters 0, immediately (asynchronous); targets/tags need not reset.
REQ-033 During and after reset until first allocation: pred_taken=0, pred_target=if_pc+4, redirect=0, flush=0.
REQ-034 Reset asserted mid-update: update discarded; state is reset values on release.

Verification
REQ-035 After reset, branch at 0x100 resolves taken to 0x80 with pred 0 -> redirect=1, redirect_pc=0x80, flush=1; next cycle if_pc=0x100 gives pred_taken=1, pred_target=0x80; counters 1/1.
REQ-036 Same branch taken 3 more times, then not-taken with pred 1 -> redirect_pc=0x104; ctr sequence 2,3,3,3,2; pred still taken afterwards.
REQ-037 Two not-taken in a row from ctr=2 -> ctr 1 then 0, pred_taken=0; not-taken resolution at pred 0 -> redirect=0.
REQ-038 Aliasing: 0x100 and 0x100+4*ENTRIES both taken -> second overwrites entry; lookup of 0x100 misses.
REQ-039 stall=1 for 5 cycles with mispredicting branch in EX -> no redirect, counters unchanged; stall drops -> single redirect, counters +1.
REQ-040 Preload mispredict_count to all-ones via forced mispredicts (or CNT_W=4 build) -> further mispredicts leave it all-ones; async rst_n pulse mid-cycle clears it to 0 without a clock edge.
